// File: rtl/multi_bit_sreg_tap.sv
// Multi-channel clock-enabled delay line with a runtime tap.
// Tracks fill depth so the selected tap reports when it holds real data.
module multi_bit_sreg_tap #(
    parameter int DW        = 4,
    parameter int CH        = 2,
    parameter int MAX_DEPTH = 8,
    parameter bit OUT_REG   = 1'b0,
    localparam int AW       = $clog2(MAX_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             flush,
    input  logic [AW-1:0]    tap_sel,
    input  logic [CH*DW-1:0] din,
    output logic [CH*DW-1:0] dout,
    output logic             dout_vld
);

    localparam int FW = $clog2(MAX_DEPTH + 1);
    localparam int WW = CH * DW;

    localparam logic [FW-1:0] DEPTH_MAX = FW'(MAX_DEPTH);
    localparam logic [FW-1:0] TAP_LAST  = FW'(MAX_DEPTH - 1);

    logic [WW-1:0] stg [MAX_DEPTH];
    logic [FW-1:0] fill_cnt;

    logic          clr;
    logic          adv;
    logic [FW-1:0] tap_ext;
    logic [FW-1:0] tap_eff;
    logic [AW-1:0] tap_idx;
    logic [FW-1:0] depth;
    logic [WW-1:0] sel_data;
    logic          sel_vld;

    // Clear dominates shifting; a shift only happens on a clean ce.
    assign clr = rst | flush;
    assign adv = ce & ~clr;

    // Stage storage: every lane shifts on the same enable.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int k = 0; k < MAX_DEPTH; k++) begin
                stg[k] <= '0;
            end
        end else if (adv) begin
            stg[0] <= din;
            for (int k = 1; k < MAX_DEPTH; k++) begin
                stg[k] <= stg[k-1];
            end
        end
    end

    // Fill count saturates at the full depth so it never wraps.
    always_ff @(posedge clk) begin
        if (clr) begin
            fill_cnt <= '0;
        end else if (adv && (fill_cnt != DEPTH_MAX)) begin
            fill_cnt <= fill_cnt + FW'(1);
        end
    end

    // Clamp an out-of-range tap to the last stage, then select it.
    always_comb begin
        tap_ext  = FW'(tap_sel);
        tap_eff  = (tap_ext >= DEPTH_MAX) ? TAP_LAST : tap_ext;
        tap_idx  = AW'(tap_eff);
        depth    = tap_eff + FW'(1);
        sel_data = stg[tap_idx];
        sel_vld  = (fill_cnt >= depth);
    end

    generate
        if (OUT_REG) begin : g_oreg
            logic [WW-1:0] dout_q;
            logic          vld_q;

            // Output stage samples the tap every clock, regardless of ce.
            always_ff @(posedge clk) begin
                if (clr) begin
                    dout_q <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    dout_q <= sel_data;
                    vld_q  <= sel_vld;
                end
            end

            assign dout     = dout_q;
            assign dout_vld = vld_q;
        end else begin : g_comb
            assign dout     = sel_data;
            assign dout_vld = sel_vld;
        end
    endgenerate

endmodule
